// File: rtl/lab5_mcore_net_msg_to_mem_req_queue.sv
// rtl/lab5_mcore_net_msg_to_mem_req_queue.sv - network-message to memory-request 2-entry queue
// Unpacks a routed network message, re-tags opaque with the source port, and buffers it for a cache bank.
module lab5_mcore_net_msg_to_mem_req_queue #(
  parameter int p_bank_id           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 2,
  localparam int c_type_nbits = 3,
  localparam int c_len_nbits  = $clog2(p_mem_data_nbits / 8),
  localparam int c_low_nbits  = p_mem_addr_nbits + c_len_nbits + p_mem_data_nbits,
  localparam int c_req_nbits  = c_type_nbits + p_mem_opaque_nbits + c_low_nbits,
  localparam int c_net_nbits  = c_req_nbits + p_net_opaque_nbits + 2 * p_net_srcdest_nbits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [c_net_nbits-1:0] net_msg,
  input  logic                   net_val,
  output logic                   net_rdy,
  output logic [c_req_nbits-1:0] mem_req_msg,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [1:0]             occupancy,
  output logic [7:0]             err_count,
  output logic                   err_flag
);

  localparam int c_keep_nbits = p_mem_opaque_nbits - p_net_srcdest_nbits;

  // Net layout (MSB first): dest, src, net opaque, payload {type, opaque, addr, len, data}
  logic [p_net_srcdest_nbits-1:0] net_dest;
  logic [p_net_srcdest_nbits-1:0] net_src;
  logic [p_net_opaque_nbits-1:0]  net_opaque;
  logic [c_type_nbits-1:0]        pay_type;
  logic [p_mem_opaque_nbits-1:0]  pay_opaque;
  logic [c_low_nbits-1:0]         pay_low;
  logic [c_req_nbits-1:0]         enq_msg;
  logic                           misrouted;
  logic                           unused_bits;

  assign net_dest   = net_msg[c_net_nbits-1 -: p_net_srcdest_nbits];
  assign net_src    = net_msg[c_net_nbits-p_net_srcdest_nbits-1 -: p_net_srcdest_nbits];
  assign net_opaque = net_msg[c_req_nbits+p_net_opaque_nbits-1 -: p_net_opaque_nbits];
  assign pay_type   = net_msg[c_req_nbits-1 -: c_type_nbits];
  assign pay_opaque = net_msg[c_req_nbits-c_type_nbits-1 -: p_mem_opaque_nbits];
  assign pay_low    = net_msg[c_low_nbits-1:0];
  assign enq_msg    = {pay_type, net_src, pay_opaque[c_keep_nbits-1:0], pay_low};
  assign unused_bits = ^{net_opaque, pay_opaque[p_mem_opaque_nbits-1 -: p_net_srcdest_nbits]};

  assign misrouted = (32'(net_dest) != 32'(p_bank_id)) || (32'(net_dest) >= 32'(p_num_ports));

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [7:0] err_count_q, err_count_d;
  logic       err_flag_q, err_flag_d;
  logic [c_req_nbits-1:0] mem_q [2];

  logic in_fire, enq, deq, drop;

  assign net_rdy     = (count_q != 2'd2);
  assign mem_req_val = (count_q != 2'd0);
  assign mem_req_msg = mem_q[rd_ptr_q];
  assign occupancy   = count_q;
  assign err_count   = err_count_q;
  assign err_flag    = err_flag_q;

  assign in_fire = net_val && net_rdy;
  assign enq     = in_fire && !misrouted;
  assign drop    = in_fire && misrouted;
  assign deq     = mem_req_val && mem_req_rdy;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (deq) rd_ptr_d = ~rd_ptr_q;
    if (enq && !deq) count_d = count_q + 2'd1;
    if (!enq && deq) count_d = count_q - 2'd1;
    if (drop) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      err_count_q <= 8'd0;
      err_flag_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  // Payload storage is left unreset; it is only observed while mem_req_val is high.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_msg;
  end

endmodule

// File: doc/lab5_mcore_net_msg_to_mem_req_queue.md
LAB5_MCORE_NET_MSG_TO_MEM_REQ_QUEUE -- requirements
Module: lab5_mcore_net_msg_to_mem_req_queue

Interface
REQ-001 Parameter p_bank_id, 0: bank index this block serves; valid range 0..p_num_ports-1.
REQ-002 Parameter p_num_ports, 4: number of network ports.
REQ-003 Parameters p_mem_opaque_nbits 8, p_mem_addr_nbits 32, p_mem_data_nbits 32: memory request field widths.
REQ-004 Parameters p_net_opaque_nbits 4, p_net_srcdest_nbits 2: network header field widths.
REQ-005 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port net_msg, input, VC_NET_MSG_NBITS(P,4,2) where P = VC_MEM_REQ_MSG_NBITS(8,32,32): incoming network message; payload is a packed memory request.
REQ-008 Port net_val / net_rdy, input / output, 1 each: val/rdy handshake on net_msg.
REQ-009 Port mem_req_msg, output, VC_MEM_REQ_MSG_NBITS(8,32,32): request toward the cache bank.
REQ-010 Port mem_req_val / mem_req_rdy, output / input, 1 each: val/rdy handshake on mem_req_msg.
REQ-011 Port occupancy, output, 2: current number of buffered entries (0..2).
REQ-012 Port err_count, output, 8: saturating count of misrouted messages.
REQ-013 Port err_flag, output, 1: sticky; high once any misrouted message has been accepted.

Function
REQ-014 Input transfer occurs when net_val && net_rdy on a rising edge; output transfer when mem_req_val && mem_req_rdy.
REQ-015 Storage is a 2-entry FIFO with wrapping 1-bit read and write pointers and a 2-bit count.
REQ-016 net_rdy = (count != 2); it does not depend on mem_req_rdy (no bypass, no same-cycle enqueue into a full buffer).
REQ-017 mem_req_val = (count != 0); mem_req_msg shows the entry at the read pointer, driven from registers.
REQ-018 Minimum latency: message accepted at edge N is presented on mem_req_msg with mem_req_val=1 in the cycle after edge N.
REQ-019 Fields are unpacked from the net payload; type, addr, len and data are forwarded unchanged.
REQ-020 Forwarded opaque = {net src, payload opaque[5:0]}; the top p_net_srcdest_nbits of opaque are always overwritten with the network src field.
REQ-021 Routing check: net dest != p_bank_id marks the message as misrouted.
REQ-022 A misrouted message is accepted under the same net_rdy rule but not enqueued; err_count increments by 1, saturating at 8'hff, and err_flag sets.
REQ-023 Simultaneous enqueue and dequeue with count==1: count stays 1, both pointers advance, order preserved.
REQ-024 Simultaneous misrouted accept and dequeue: count decrements by 1 and err_count increments.
REQ-025 Entries leave in arrival order (strict FIFO), including after pointer wrap-around.
REQ-026 occupancy = count at all times.
REQ-027 Ports with X type (message idle) are ignored unless net_val=1; no state changes when net_val=0.

Reset
REQ-028 While reset=1, asynchronously: count=0, pointers=0, err_count=0, err_flag=0; hence net_rdy=1 and mem_req_val=0.
REQ-029 Reset asserted mid-operation discards all buffered entries; nothing buffered before reset appears afterward.
REQ-030 Storage data registers need no reset; mem_req_msg is don't-care while mem_req_val=0.

Verification
REQ-031 p_bank_id=1, mem_req_rdy=1; send read opaque 8'h80, addr 32'h00001010, len 0, src 2, dest 1 -> next cycle mem_req_val=1, opaque 8'h80, addr 32'h00001010, occupancy 1, then 0.
REQ-032 mem_req_rdy=0; send three valid write messages back-to-back -> two accepted, net_rdy=0 on third, occupancy 2; raise mem_req_rdy -> outputs in order, third accepted after first dequeue.
REQ-033 Send write opaque 8'h13, src 3, dest 0 with p_bank_id=1 -> not forwarded, err_count 1, err_flag 1, occupancy unchanged.
REQ-034 Payload opaque 8'h05, net src 2 -> forwarded opaque 8'h85.
REQ-035 Continuous stream of 6 messages with count==1 and both handshakes every cycle -> one message out per cycle, order preserved across pointer wrap.
REQ-036 Assert reset with occupancy 2 and err_count 3 -> immediately occupancy 0, mem_req_val 0, err_count 0, err_flag 0, net_rdy 1.
